icache_ctrl: RTL

- Direct-mapped instruction cache between the CPU fetch path and the instruction memory.
- Produces the BUSYWAIT that stalls the PC adder and PC register.
- On a hit, returns the 32-bit instruction in the same cycle.
- On a miss, raises BUSYWAIT, fetches a 16-byte block over the memory handshake, installs it, then serves the fetch.

---
 rtl/icache_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache with a single-block fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 10
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic              READ,
    output logic [31:0]       READDATA,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic [ADDR_W-5:0] MEM_ADDRESS,
    input  logic [127:0]      MEM_READDATA,
    input  logic              MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]       HIT_COUNT,
    output logic [15:0]       MISS_COUNT
`endif
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FILL
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag  [NUM_BLOCKS];
    logic [127:0]      r_data [NUM_BLOCKS];
    logic [ADDR_W-5:0] r_blk_addr;
    logic [127:0]      r_fill;
    logic [31:0]       r_rdata;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [1:0]        w_off;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic [127:0]      w_line;
    logic [31:0]       w_word;
    logic              w_hit;
    logic              w_miss;
    logic              w_unused;

    assign w_idx      = ADDRESS[IDX_W+3:4];
    assign w_tag      = ADDRESS[ADDR_W-1:IDX_W+4];
    assign w_off      = ADDRESS[3:2];
    assign w_fill_idx = r_blk_addr[IDX_W-1:0];
    assign w_fill_tag = r_blk_addr[ADDR_W-5:IDX_W];
    assign w_line     = r_data[w_idx];
    assign w_word     = w_line[{w_off, 5'b0} +: 32];
    assign w_unused   = ^ADDRESS[1:0];

    // Lookup only counts in IDLE, so hit and miss are mutually exclusive by construction.
    assign w_hit  = (r_state == S_IDLE) & READ & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss = (r_state == S_IDLE) & READ & ~w_hit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_next = S_FETCH;
            S_FETCH: if (!MEM_BUSYWAIT) w_next = S_FILL;
            S_FILL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Gating with RESET_N keeps the stall low while reset is held, even with READ high.
    assign BUSYWAIT    = RESET_N & ((r_state != S_IDLE) | w_miss);
    assign MEM_READ    = (r_state == S_FETCH);
    assign MEM_ADDRESS = r_blk_addr;
    assign READDATA    = w_hit ? w_word : r_rdata;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_blk_addr <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_hit)
                r_rdata <= w_word;
            if (w_miss)
                r_blk_addr <= ADDRESS[ADDR_W-1:4];
            if (r_state == S_FILL)
                r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == S_FETCH && !MEM_BUSYWAIT)
            r_fill <= MEM_READDATA;
        if (r_state == S_FILL) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= r_fill;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && r_hit_cnt != 16'hFFFF)
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss && r_miss_cnt != 16'hFFFF)
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign HIT_COUNT  = r_hit_cnt;
    assign MISS_COUNT = r_miss_cnt;
`endif

endmodule
